level_sequencer: RTL and testbench



---
 rtl/level_sequencer_pkg.sv | 20 ++
 rtl/level_sequencer_if.sv | 27 ++
 rtl/level_sequencer_spawn_rom.sv | 11 +
 rtl/level_sequencer.sv | 115 +++++++++++
 tb/tb_level_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/level_sequencer_pkg.sv
// level_sequencer_pkg: shared state encoding, counter width and per-level spawn table.
package level_sequencer_pkg;
  localparam int CNT_W = 8;
  localparam int COORD_W = 10;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY     = 3'd1,
    S_DYING    = 3'd2,
    S_TRANS    = 3'd3,
    S_WIN      = 3'd4,
    S_GAMEOVER = 3'd5
  } state_t;
  // Element [0] is the rightmost entry: level 0 spawns at (304,220).
  localparam logic [7:0][COORD_W-1:0] SPAWN_X = {
    10'd480, 10'd160, 10'd320, 10'd560, 10'd80, 10'd520, 10'd120, 10'd304
  };
  localparam logic [7:0][COORD_W-1:0] SPAWN_Y = {
    10'd240, 10'd60, 10'd400, 10'd100, 10'd120, 10'd380, 10'd380, 10'd220
  };
endpackage

// File: rtl/level_sequencer_if.sv
// level_sequencer_if: game-event inputs and sequencer status outputs.
interface level_sequencer_if;
  import level_sequencer_pkg::*;
  logic start;
  logic death_evt;
  logic exit_evt;
  logic chkpt_evt;
  logic [COORD_W-1:0] chkpt_x;
  logic [COORD_W-1:0] chkpt_y;
  logic [2:0] level;
  logic [COORD_W-1:0] spawn_x;
  logic [COORD_W-1:0] spawn_y;
  logic respawn;
  logic freeze;
  logic [1:0] lives;
  logic [2:0] state;
  logic game_won;
  logic game_over;
  modport master (
    output start, death_evt, exit_evt, chkpt_evt, chkpt_x, chkpt_y,
    input  level, spawn_x, spawn_y, respawn, freeze, lives, state, game_won, game_over
  );
  modport slave (
    input  start, death_evt, exit_evt, chkpt_evt, chkpt_x, chkpt_y,
    output level, spawn_x, spawn_y, respawn, freeze, lives, state, game_won, game_over
  );
endinterface

// File: rtl/level_sequencer_spawn_rom.sv
// spawn_rom: combinational level -> spawn centre lookup.
module spawn_rom
  import level_sequencer_pkg::*;
(
  input  logic [2:0]         level,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);
  assign x = SPAWN_X[level];
  assign y = SPAWN_Y[level];
endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: game-flow FSM tracking level, lives, checkpoints and respawn timing.
module level_sequencer
  import level_sequencer_pkg::*;
#(
  parameter int NUM_LEVELS = 8,
  parameter int LIVES_INIT = 3,
  parameter int DEATH_HOLD = 60,
  parameter int TRANS_HOLD = 30
) (
  input logic clk,
  input logic rst,
  level_sequencer_if.slave bus
);
  state_t state;
  logic [2:0] level, lvl_n;
  logic [1:0] lives;
  logic [CNT_W-1:0] cnt;
  logic start_q, respawn, freeze, game_won, game_over;
  logic cp_valid, cv_n;
  logic [COORD_W-1:0] cp_x, cp_y, cx_n, cy_n, rom_x, rom_y, spawn_x, spawn_y;
  logic idle_like, go, play, d, e, c, adv;
  always_comb begin
    idle_like = !(state inside {S_PLAY, S_DYING, S_TRANS});
    go = idle_like && bus.start && !start_q;
    play = state == S_PLAY;
    d = play && bus.death_evt;
    e = play && !bus.death_evt && bus.exit_evt;
    c = play && !bus.death_evt && !bus.exit_evt && bus.chkpt_evt;
    adv = e && (level < 3'(NUM_LEVELS - 1));
    lvl_n = go ? 3'd0 : adv ? level + 3'd1 : level;
    cv_n = (go || adv) ? 1'b0 : c ? 1'b1 : cp_valid;
    cx_n = c ? bus.chkpt_x : cp_x;
    cy_n = c ? bus.chkpt_y : cp_y;
  end
  // Looked up on the next level so spawn is already correct on the respawn cycle.
  spawn_rom u_rom (.level(lvl_n), .x(rom_x), .y(rom_y));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      level <= '0;
      lives <= 2'(LIVES_INIT);
      cnt <= '0;
      start_q <= 1'b0;
      respawn <= 1'b0;
      freeze <= 1'b1;
      game_won <= 1'b0;
      game_over <= 1'b0;
      cp_valid <= 1'b0;
      cp_x <= '0;
      cp_y <= '0;
      spawn_x <= SPAWN_X[0];
      spawn_y <= SPAWN_Y[0];
    end else begin
      start_q <= bus.start;
      respawn <= 1'b0;
      level <= lvl_n;
      cp_valid <= cv_n;
      cp_x <= cx_n;
      cp_y <= cy_n;
      spawn_x <= cv_n ? cx_n : rom_x;
      spawn_y <= cv_n ? cy_n : rom_y;
      case (state)
        S_PLAY: begin
          if (d) begin
            lives <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
            freeze <= 1'b1;
            if (lives <= 2'd1) begin
              state <= S_GAMEOVER;
              game_over <= 1'b1;
            end else begin
              state <= S_DYING;
              cnt <= CNT_W'(DEATH_HOLD - 1);
            end
          end else if (e) begin
            freeze <= 1'b1;
            if (adv) begin
              state <= S_TRANS;
              cnt <= CNT_W'(TRANS_HOLD - 1);
            end else begin
              state <= S_WIN;
              game_won <= 1'b1;
            end
          end
        end
        S_DYING, S_TRANS: begin
          if (cnt == '0) begin
            state <= S_PLAY;
            respawn <= 1'b1;
            freeze <= 1'b0;
          end else
            cnt <= cnt - 1'b1;
        end
        default: begin
          if (go) begin
            state <= S_PLAY;
            lives <= 2'(LIVES_INIT);
            respawn <= 1'b1;
            freeze <= 1'b0;
            game_won <= 1'b0;
            game_over <= 1'b0;
          end
        end
      endcase
    end
  end
  assign bus.level = level;
  assign bus.spawn_x = spawn_x;
  assign bus.spawn_y = spawn_y;
  assign bus.respawn = respawn;
  assign bus.freeze = freeze;
  assign bus.lives = lives;
  assign bus.state = state;
  assign bus.game_won = game_won;
  assign bus.game_over = game_over;
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed scenario tests with hand-computed expectations.
module tb_level_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int ex[8] = '{304, 120, 520, 80, 560, 320, 160, 480};
  int ey[8] = '{220, 380, 380, 120, 100, 400, 60, 240};
  level_sequencer_if bus();
  level_sequencer #(.NUM_LEVELS(8), .LIVES_INIT(3), .DEATH_HOLD(4), .TRANS_HOLD(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic begin_game;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic test_reset;
    bus.start = 0; bus.death_evt = 0; bus.exit_evt = 0; bus.chkpt_evt = 0;
    bus.chkpt_x = 0; bus.chkpt_y = 0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.state, bus.level, bus.lives, bus.respawn, bus.freeze, bus.game_won, bus.game_over}
        !== {3'd0, 3'd0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_status got st=%0d lv=%0d li=%0d rs=%b fz=%b w=%b o=%b want 0 0 3 0 1 0 0",
               bus.state, bus.level, bus.lives, bus.respawn, bus.freeze, bus.game_won, bus.game_over);
    end
    checks++;
    if ({bus.spawn_x, bus.spawn_y} !== {10'd304, 10'd220}) begin
      errors++;
      $display("FAIL reset_spawn got (%0d,%0d) want (304,220)", bus.spawn_x, bus.spawn_y);
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_start;
    bus.start = 1'b1;
    tick();
    checks++;
    if ({bus.state, bus.respawn, bus.freeze, bus.lives, bus.level, bus.spawn_x, bus.spawn_y}
        !== {3'd1, 1'b1, 1'b0, 2'd3, 3'd0, 10'd304, 10'd220}) begin
      errors++;
      $display("FAIL start_play got st=%0d rs=%b fz=%b li=%0d lv=%0d sp=(%0d,%0d) want 1 1 0 3 0 (304,220)",
               bus.state, bus.respawn, bus.freeze, bus.lives, bus.level, bus.spawn_x, bus.spawn_y);
    end
    tick();
    checks++;
    if ({bus.state, bus.respawn} !== {3'd1, 1'b0}) begin
      errors++;
      $display("FAIL start_held got st=%0d rs=%b want 1 0", bus.state, bus.respawn);
    end
    bus.start = 1'b0;
  endtask
  task automatic test_death;
    begin_game();
    tick();
    bus.death_evt = 1'b1;
    tick();
    bus.death_evt = 1'b0;
    checks++;
    if ({bus.state, bus.lives, bus.freeze} !== {3'd2, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL death_enter got st=%0d li=%0d fz=%b want 2 2 1", bus.state, bus.lives, bus.freeze);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.state, bus.freeze, bus.respawn} !== {3'd2, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL death_hold%0d got st=%0d fz=%b rs=%b want 2 1 0", i, bus.state, bus.freeze, bus.respawn);
      end
    end
    tick();
    checks++;
    if ({bus.state, bus.respawn, bus.freeze, bus.spawn_x, bus.spawn_y}
        !== {3'd1, 1'b1, 1'b0, 10'd304, 10'd220}) begin
      errors++;
      $display("FAIL death_respawn got st=%0d rs=%b fz=%b sp=(%0d,%0d) want 1 1 0 (304,220)",
               bus.state, bus.respawn, bus.freeze, bus.spawn_x, bus.spawn_y);
    end
    tick();
    checks++;
    if (bus.respawn !== 1'b0) begin
      errors++;
      $display("FAIL death_pulse_width got rs=%b want 0", bus.respawn);
    end
  endtask
  task automatic test_checkpoint;
    begin_game();
    bus.chkpt_evt = 1'b1; bus.chkpt_x = 10'd500; bus.chkpt_y = 10'd300;
    tick();
    bus.chkpt_evt = 1'b0;
    checks++;
    if ({bus.state, bus.spawn_x, bus.spawn_y} !== {3'd1, 10'd500, 10'd300}) begin
      errors++;
      $display("FAIL chkpt_latch got st=%0d sp=(%0d,%0d) want 1 (500,300)", bus.state, bus.spawn_x, bus.spawn_y);
    end
    bus.death_evt = 1'b1;
    tick();
    bus.death_evt = 1'b0;
    repeat (4) tick();
    checks++;
    if ({bus.state, bus.respawn, bus.spawn_x, bus.spawn_y} !== {3'd1, 1'b1, 10'd500, 10'd300}) begin
      errors++;
      $display("FAIL chkpt_respawn got st=%0d rs=%b sp=(%0d,%0d) want 1 1 (500,300)",
               bus.state, bus.respawn, bus.spawn_x, bus.spawn_y);
    end
    bus.exit_evt = 1'b1;
    tick();
    bus.exit_evt = 1'b0;
    checks++;
    if ({bus.state, bus.level, bus.spawn_x, bus.spawn_y} !== {3'd3, 3'd1, 10'(ex[1]), 10'(ey[1])}) begin
      errors++;
      $display("FAIL exit_clears_chkpt got st=%0d lv=%0d sp=(%0d,%0d) want 3 1 (%0d,%0d)",
               bus.state, bus.level, bus.spawn_x, bus.spawn_y, ex[1], ey[1]);
    end
    repeat (3) tick();
    checks++;
    if ({bus.state, bus.respawn, bus.freeze} !== {3'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL trans_respawn got st=%0d rs=%b fz=%b want 1 1 0", bus.state, bus.respawn, bus.freeze);
    end
  endtask
  task automatic test_simultaneous;
    begin_game();
    bus.death_evt = 1'b1; bus.exit_evt = 1'b1; bus.chkpt_evt = 1'b1;
    bus.chkpt_x = 10'd1; bus.chkpt_y = 10'd2;
    tick();
    bus.death_evt = 1'b0; bus.exit_evt = 1'b0; bus.chkpt_evt = 1'b0;
    checks++;
    if ({bus.state, bus.level, bus.lives, bus.spawn_x, bus.spawn_y}
        !== {3'd2, 3'd0, 2'd2, 10'd304, 10'd220}) begin
      errors++;
      $display("FAIL priority got st=%0d lv=%0d li=%0d sp=(%0d,%0d) want 2 0 2 (304,220)",
               bus.state, bus.level, bus.lives, bus.spawn_x, bus.spawn_y);
    end
  endtask
  task automatic test_gameover;
    begin_game();
    for (int k = 0; k < 3; k++) begin
      bus.death_evt = 1'b1;
      tick();
      bus.death_evt = 1'b0;
      if (k < 2) repeat (4) tick();
    end
    checks++;
    if ({bus.state, bus.lives, bus.game_over, bus.freeze} !== {3'd5, 2'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL gameover got st=%0d li=%0d go=%b fz=%b want 5 0 1 1",
               bus.state, bus.lives, bus.game_over, bus.freeze);
    end
    bus.death_evt = 1'b1; bus.exit_evt = 1'b1;
    tick();
    bus.death_evt = 1'b0; bus.exit_evt = 1'b0;
    checks++;
    if ({bus.state, bus.lives, bus.level} !== {3'd5, 2'd0, 3'd0}) begin
      errors++;
      $display("FAIL gameover_ignore got st=%0d li=%0d lv=%0d want 5 0 0", bus.state, bus.lives, bus.level);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.state, bus.lives, bus.level, bus.respawn, bus.game_over} !== {3'd1, 2'd3, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL restart got st=%0d li=%0d lv=%0d rs=%b go=%b want 1 3 0 1 0",
               bus.state, bus.lives, bus.level, bus.respawn, bus.game_over);
    end
  endtask
  task automatic test_win;
    begin_game();
    for (int lv = 0; lv < 7; lv++) begin
      bus.exit_evt = 1'b1;
      tick();
      bus.exit_evt = 1'b0;
      checks++;
      if ({bus.state, bus.level, bus.spawn_x, bus.spawn_y}
          !== {3'd3, 3'(lv + 1), 10'(ex[lv+1]), 10'(ey[lv+1])}) begin
        errors++;
        $display("FAIL advance%0d got st=%0d lv=%0d sp=(%0d,%0d) want 3 %0d (%0d,%0d)", lv,
                 bus.state, bus.level, bus.spawn_x, bus.spawn_y, lv + 1, ex[lv+1], ey[lv+1]);
      end
      repeat (3) tick();
    end
    bus.exit_evt = 1'b1;
    tick();
    bus.exit_evt = 1'b0;
    checks++;
    if ({bus.state, bus.game_won, bus.freeze, bus.level} !== {3'd4, 1'b1, 1'b1, 3'd7}) begin
      errors++;
      $display("FAIL win got st=%0d w=%b fz=%b lv=%0d want 4 1 1 7", bus.state, bus.game_won, bus.freeze, bus.level);
    end
    bus.exit_evt = 1'b1;
    tick();
    bus.exit_evt = 1'b0;
    checks++;
    if ({bus.state, bus.level} !== {3'd4, 3'd7}) begin
      errors++;
      $display("FAIL win_ignore got st=%0d lv=%0d want 4 7", bus.state, bus.level);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.state, bus.level, bus.game_won, bus.spawn_x, bus.spawn_y}
        !== {3'd1, 3'd0, 1'b0, 10'd304, 10'd220}) begin
      errors++;
      $display("FAIL win_restart got st=%0d lv=%0d w=%b sp=(%0d,%0d) want 1 0 0 (304,220)",
               bus.state, bus.level, bus.game_won, bus.spawn_x, bus.spawn_y);
    end
  endtask
  task automatic test_reset_abort;
    logic seen;
    begin_game();
    for (int i = 0; i < 3; i++) begin
      bus.exit_evt = 1'b1;
      tick();
      bus.exit_evt = 1'b0;
      if (i < 2) repeat (3) tick();
    end
    tick();
    checks++;
    if ({bus.state, bus.level} !== {3'd3, 3'd3}) begin
      errors++;
      $display("FAIL abort_setup got st=%0d lv=%0d want 3 3", bus.state, bus.level);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.state, bus.level, bus.freeze} !== {3'd0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL abort_async got st=%0d lv=%0d fz=%b want 0 0 1", bus.state, bus.level, bus.freeze);
    end
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | bus.respawn | (bus.state != 3'd0);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_respawn got activity=%b want 0", seen);
    end
  endtask
  initial begin
    test_reset();
    test_start();
    test_death();
    test_checkpoint();
    test_simultaneous();
    test_gameover();
    test_win();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
